// File: rtl/gon_pkg.sv
// Shared types and default dimensions for the GON row gather bus.
package gon_pkg;

  localparam int DEF_MASTER_NUMS = 14;
  localparam int DEF_ID_LEN      = 5;
  localparam int DEF_VALUE_LEN   = 32;
  localparam int ROW_LEN         = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } gon_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gon_bus_if.sv
// Request, output, PE-side and ID-scan signals of one GON gather bus.
// slave is the bus itself; master is the controller/PE/downstream environment.
interface gon_bus_if
  import gon_pkg::*;
#(
  parameter int MASTER_NUMS = DEF_MASTER_NUMS,
  parameter int ID_LEN      = DEF_ID_LEN,
  parameter int VALUE_LEN   = DEF_VALUE_LEN
) ();

  logic                             req_enable;
  logic                             req_ready;
  logic [ID_LEN-1:0]                req_tag;
  logic                             out_valid;
  logic                             out_ready;
  logic [VALUE_LEN-1:0]             out_data;
  logic [ID_LEN-1:0]                out_tag;
  logic [ROW_LEN-1:0]               out_row;
  logic                             out_last;
  logic [MASTER_NUMS-1:0]           pe_valid;
  logic [MASTER_NUMS*VALUE_LEN-1:0] pe_data;
  logic [MASTER_NUMS-1:0]           pe_ready;
  logic                             set_id;
  logic [ID_LEN-1:0]                id_scan_in;
  logic [ID_LEN-1:0]                id_scan_out;

  modport slave (
    input  req_enable, req_tag, out_ready, pe_valid, pe_data, set_id, id_scan_in,
    output req_ready, out_valid, out_data, out_tag, out_row, out_last, pe_ready, id_scan_out
  );

  modport master (
    output req_enable, req_tag, out_ready, pe_valid, pe_data, set_id, id_scan_in,
    input  req_ready, out_valid, out_data, out_tag, out_row, out_last, pe_ready, id_scan_out
  );

endinterface

// File: rtl/gon_prio_sel.sv
// Combinational lowest-set-bit picker: one-hot grant plus binary index.
// An all-zero request yields zero on both outputs.
module gon_prio_sel #(
  parameter int N     = 14,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/gon_bus.sv
// GON row gather bus: drains tag-matched PEs lowest index first, summed when GON_REDUCE_EN is defined.
// Registered output, first value 2 cycles after accept; a PE is acked only when its value can be taken.
module gon_bus
  import gon_pkg::*;
#(
  parameter int MASTER_NUMS = DEF_MASTER_NUMS,
  parameter int ID_LEN      = DEF_ID_LEN,
  parameter int VALUE_LEN   = DEF_VALUE_LEN,
  parameter int MA_Y        = 0
) (
  input logic      clk,
  input logic      rst,
  gon_bus_if.slave bus
);

  localparam int IDX_W = idx_width(MASTER_NUMS);

  gon_state_t             state;
  logic                   req_ready_q;
  logic [ID_LEN-1:0]      id [MASTER_NUMS];
  logic [ID_LEN-1:0]      tag_r;
  logic [MASTER_NUMS-1:0] pend;
  logic [MASTER_NUMS-1:0] match;
  logic [MASTER_NUMS-1:0] sel_oh;
  logic [IDX_W-1:0]       sel_idx;
  logic [VALUE_LEN-1:0]   sel_data;
  logic [VALUE_LEN-1:0]   load_val;
  logic                   sel_vld;
  logic                   last_one;
  logic                   slot_free;
  logic                   capture;
  logic                   load;
  logic                   load_last;

  logic                   out_valid_q;
  logic [VALUE_LEN-1:0]   out_data_q;
  logic [ID_LEN-1:0]      out_tag_q;
  logic                   out_last_q;

  gon_prio_sel #(
    .N     (MASTER_NUMS),
    .IDX_W (IDX_W)
  ) u_prio_sel (
    .req    (pend),
    .onehot (sel_oh),
    .idx    (sel_idx)
  );

  always_comb begin
    match = '0;
    for (int i = 0; i < MASTER_NUMS; i++) begin
      match[i] = (id[i] == bus.req_tag);
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < MASTER_NUMS; i++) begin
      if (sel_oh[i]) sel_data = bus.pe_data[i*VALUE_LEN +: VALUE_LEN];
    end
  end

  assign sel_vld   = (|pend) && bus.pe_valid[sel_idx];
  assign last_one  = ((pend & ~sel_oh) == '0);
  assign slot_free = !out_valid_q || bus.out_ready;

`ifdef GON_REDUCE_EN
  logic [VALUE_LEN-1:0] acc;

  // Partial sums stay internal, so only the final capture needs the output slot.
  assign capture   = (state == COLLECT) && sel_vld && (slot_free || !last_one);
  assign load      = capture && last_one;
  assign load_val  = acc + sel_data;
  assign load_last = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (state == IDLE && bus.req_enable && req_ready_q) begin
      acc <= '0;
    end else if (capture) begin
      acc <= load_val;
    end
  end
`else
  assign capture   = (state == COLLECT) && sel_vld && slot_free;
  assign load      = capture;
  assign load_val  = sel_data;
  assign load_last = last_one;
`endif

  // Gated by rst so a PE is never acknowledged for a value that reset discards.
  assign bus.pe_ready = (capture && !rst) ? sel_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      tag_r       <= '0;
      pend        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < MASTER_NUMS; i++) id[i] <= '0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= load_val;
        out_tag_q   <= tag_r;
        out_last_q  <= load_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.set_id) begin
            id[0] <= bus.id_scan_in;
            for (int i = 1; i < MASTER_NUMS; i++) id[i] <= id[i-1];
          end
          if (bus.req_enable) begin
            tag_r       <= bus.req_tag;
            pend        <= match;
            state       <= COLLECT;
            req_ready_q <= 1'b0;
          end
        end
        COLLECT: begin
          if (capture) pend <= pend & ~sel_oh;
          if (pend == '0 || (capture && last_one)) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_row     = ROW_LEN'(MA_Y);
  assign bus.id_scan_out = id[MASTER_NUMS-1];

endmodule

// File: tb/tb_gon_bus.sv
// Bench for gon_bus: directed cases plus randomized requests, checked by a queue scoreboard.
module tb_gon_bus;

  localparam int N    = 14;
  localparam int IW   = 5;
  localparam int VW   = 32;
  localparam int MA_Y = 0;

  typedef struct packed {
    logic [VW-1:0] data;
    logic [IW-1:0] tag;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  gon_bus_if #(.MASTER_NUMS(N), .ID_LEN(IW), .VALUE_LEN(VW)) bus ();

  gon_bus #(
    .MASTER_NUMS (N),
    .ID_LEN      (IW),
    .VALUE_LEN   (VW),
    .MA_Y        (MA_Y)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [VW-1:0] d    [N];
  logic [IW-1:0] mid  [N];
  logic [IW-1:0] want [N];
  logic [N-1:0]  pe_mask = '0;
  logic [N-1:0]  pe_took = '0;
  int            v_pct   = 100;
  int            r_pct   = 100;

  exp_t exp_q[$];
  int   drain_q[$];

  exp_t          mon_e;
  logic          stall = 1'b0;
  logic [VW-1:0] st_data;
  logic [IW-1:0] st_tag;
  logic          st_last;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
  endfunction

  // PE and downstream side: a PE offers d[i]; once taken, it produces a fresh random value.
  initial begin
    bus.pe_valid  = '0;
    bus.pe_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) d[i] = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (pe_took[i]) d[i] = $urandom;
        bus.pe_valid[i]        = pe_mask[i] && ($urandom_range(99) < v_pct);
        bus.pe_data[i*VW +: VW] = d[i];
      end
      bus.out_ready = ($urandom_range(99) < r_pct);
    end
  end

  // Monitor: PE acknowledges against the drain order, outputs against the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      pe_took = '0;
      stall   = 1'b0;
    end else begin
      pe_took = bus.pe_valid & bus.pe_ready;
      if (bus.pe_ready != '0) begin
        check("pe_ready_without_valid", 64'(bus.pe_ready & ~bus.pe_valid), 64'd0);
        if (drain_q.size() == 0) begin
          check("pe_ready_unexpected", 64'(bus.pe_ready), 64'd0);
        end else begin
          check("pe_ready_order", 64'(bus.pe_ready), 64'd1 << drain_q[0]);
          if (pe_took != '0) void'(drain_q.pop_front());
        end
      end
      if (stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'(bus.out_data), 64'(st_data));
        check("hold_tag", 64'(bus.out_tag), 64'(st_tag));
        check("hold_last", 64'(bus.out_last), 64'(st_last));
      end
      if (bus.out_valid) check("out_row", 64'(bus.out_row), 64'(MA_Y));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected_queue_size", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(mon_e.data));
          check("out_tag", 64'(bus.out_tag), 64'(mon_e.tag));
          check("out_last", 64'(bus.out_last), 64'(mon_e.last));
        end
      end
      stall   = bus.out_valid && !bus.out_ready;
      st_data = bus.out_data;
      st_tag  = bus.out_tag;
      st_last = bus.out_last;
    end
  end

  // Reference: every PE whose id equals the tag is drained once, ascending; reduce sums them.
  task automatic model_accept(input logic [IW-1:0] tag);
    logic [VW-1:0] sum = '0;
    int            last_i = -1;
    exp_t          e;
    for (int i = 0; i < N; i++) begin
      if (mid[i] == tag) begin
        last_i = i;
        sum    = sum + d[i];
        drain_q.push_back(i);
      end
    end
`ifdef GON_REDUCE_EN
    if (last_i >= 0) begin
      e.data = sum;
      e.tag  = tag;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
`else
    for (int i = 0; i < N; i++) begin
      if (mid[i] == tag) begin
        e.data = d[i];
        e.tag  = tag;
        e.last = (i == last_i);
        exp_q.push_back(e);
      end
    end
`endif
  endtask

  task automatic do_req(input logic [IW-1:0] tag);
    bit seen = 1'b0;
    bus.req_tag    = tag;
    bus.req_enable = 1'b1;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (bus.req_ready) seen = 1'b1;
    end
    if (!seen) check("req_accept_timeout", 64'(bus.req_ready), 64'd1);
    else model_accept(tag);
    @(posedge clk);
    #1;
    bus.req_enable = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((exp_q.size() != 0 || drain_q.size() != 0 || !bus.req_ready) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 2000) check("drain_timeout", 64'(exp_q.size() + drain_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic load_ids();
    for (int k = N - 1; k >= 0; k--) begin
      bus.set_id     = 1'b1;
      bus.id_scan_in = want[k];
      @(posedge clk);
      #1;
    end
    bus.set_id = 1'b0;
    for (int i = 0; i < N; i++) mid[i] = want[i];
  endtask

  task automatic wait_out_valid();
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    if (!seen) check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  logic [5:1]    ov_v;
  logic [5:1]    ol_v;
  logic [VW-1:0] od [1:5];
  logic [VW-1:0] held;

  initial begin
    rst            = 1'b1;
    bus.req_enable = 1'b0;
    bus.req_tag    = '0;
    bus.set_id     = 1'b0;
    bus.id_scan_in = '0;
    for (int i = 0; i < N; i++) mid[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_pe_ready", 64'(bus.pe_ready), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_id_scan_out", 64'(bus.id_scan_out), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Scan load: PE i gets id i, then a single-PE request on tag 5.
    for (int i = 0; i < N; i++) want[i] = IW'(i);
    load_ids();
    @(negedge clk);
    check("scan_out_after_load", 64'(bus.id_scan_out), 64'd13);
    @(posedge clk);
    #1;
    d[5]    = 32'hA5;
    pe_mask = N'(1) << 5;
    do_req(5'd5);
    @(negedge clk);
    check("single_pe_ready_t1", 64'(bus.pe_ready), 64'h0020);
    check("single_out_valid_t1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("single_out_valid_t2", 64'(bus.out_valid), 64'd1);
    check("single_out_data_t2", 64'(bus.out_data), 64'hA5);
    check("single_out_tag_t2", 64'(bus.out_tag), 64'd5);
    check("single_out_last_t2", 64'(bus.out_last), 64'd1);
    wait_idle();

    // Multi-match: PEs 2, 7, 9 carry id 3, the rest ids 16+i.
    for (int i = 0; i < N; i++) want[i] = IW'(16 + i);
    want[2] = 5'd3;
    want[7] = 5'd3;
    want[9] = 5'd3;
    load_ids();
    @(negedge clk);
    check("scan_out_pattern", 64'(bus.id_scan_out), 64'd29);
    @(posedge clk);
    #1;
    d[2]    = 32'd10;
    d[7]    = 32'd20;
    d[9]    = 32'd30;
    pe_mask = (N'(1) << 2) | (N'(1) << 7) | (N'(1) << 9);
    do_req(5'd3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ov_v[k] = bus.out_valid;
      ol_v[k] = bus.out_last;
      od[k]   = bus.out_data;
    end
`ifdef GON_REDUCE_EN
    check("multi_valid_pattern", 64'(ov_v), 64'b01000);
    check("multi_sum", 64'(od[4]), 64'd60);
    check("multi_sum_last", 64'(ol_v[4]), 64'd1);
`else
    check("multi_valid_pattern", 64'(ov_v), 64'b01110);
    check("multi_data_0", 64'(od[2]), 64'd10);
    check("multi_data_1", 64'(od[3]), 64'd20);
    check("multi_data_2", 64'(od[4]), 64'd30);
    check("multi_last_pattern", 64'({ol_v[4], ol_v[3], ol_v[2]}), 64'b100);
`endif
    wait_idle();

    // Wrap-around values on the same PEs.
    d[2] = 32'hFFFF_FFFF;
    d[7] = 32'd2;
    d[9] = 32'd0;
    @(posedge clk);
    #1;
    do_req(5'd3);
    wait_idle();

    // Backpressure: output stalled for 4 cycles once a value is presented.
    d[2]  = 32'd11;
    d[7]  = 32'd22;
    d[9]  = 32'd33;
    r_pct = 0;
    @(posedge clk);
    #1;
    do_req(5'd3);
    wait_out_valid();
    held = bus.out_data;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(bus.out_valid), 64'd1);
      check("bp_data_stable", 64'(bus.out_data), 64'(held));
      check("bp_no_pe_ready", 64'(bus.pe_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    r_pct = 100;
    wait_idle();

    // No match: tag 31 appears on no PE.
    do_req(5'd31);
    @(negedge clk);
    check("nomatch_req_ready_t1", 64'(bus.req_ready), 64'd0);
    check("nomatch_out_valid_t1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("nomatch_req_ready_t2", 64'(bus.req_ready), 64'd1);
    check("nomatch_out_valid_t2", 64'(bus.out_valid), 64'd0);
    wait_idle();

    // Randomized traffic over a small id space so multi-matches and misses are frequent.
    for (int i = 0; i < N; i++) want[i] = IW'($urandom_range(3));
    load_ids();
    pe_mask = '1;
    for (int r = 0; r < 40; r++) begin
      v_pct = $urandom_range(100, 40);
      r_pct = $urandom_range(100, 30);
      do_req(IW'($urandom_range(4)));
    end
    r_pct = 100;
    wait_idle();

    // Reset after the first capture of a multi-match request.
    for (int i = 0; i < N; i++) want[i] = IW'(16 + i);
    want[2] = 5'd3;
    want[7] = 5'd3;
    want[9] = 5'd3;
    load_ids();
    pe_mask = (N'(1) << 2) | (N'(1) << 7) | (N'(1) << 9);
    v_pct   = 100;
    @(posedge clk);
    #1;
    do_req(5'd3);
    wait_out_valid();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    drain_q.delete();
    for (int i = 0; i < N; i++) mid[i] = '0;
    @(negedge clk);
    check("rstmid_pe_ready_during", 64'(bus.pe_ready), 64'd0);
    @(negedge clk);
    check("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rstmid_pe_ready", 64'(bus.pe_ready), 64'd0);
    check("rstmid_req_ready", 64'(bus.req_ready), 64'd1);
    check("rstmid_id_scan_out", 64'(bus.id_scan_out), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset every PE has id 0, so tag 0 drains the whole row.
    pe_mask = '1;
    v_pct   = 70;
    r_pct   = 80;
    do_req(5'd0);
    r_pct = 100;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
